// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM among OPTN_NUM_REQ requesters.
// One request in flight at a time; retries RAM misses up to OPTN_MAX_RETRY cycles.
module data_ram_arbiter #(
    parameter int OPTN_DATA_WIDTH = 32,
    parameter int OPTN_ADDR_WIDTH = 32,
    parameter int OPTN_NUM_REQ    = 2,
    parameter int OPTN_MAX_RETRY  = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [OPTN_NUM_REQ-1:0]                       i_req_valid,
    input  logic [OPTN_NUM_REQ-1:0]                       i_req_we,
    input  logic [OPTN_NUM_REQ*OPTN_ADDR_WIDTH-1:0]       i_req_addr,
    input  logic [OPTN_NUM_REQ*OPTN_DATA_WIDTH-1:0]       i_req_data,
    input  logic [OPTN_NUM_REQ*(OPTN_DATA_WIDTH/8)-1:0]   i_req_byte_select,
    output logic [OPTN_NUM_REQ-1:0]                       o_req_ready,
    output logic [OPTN_NUM_REQ-1:0]                       o_resp_valid,
    output logic                                          o_resp_err,
    output logic [OPTN_DATA_WIDTH-1:0]                    o_resp_data,
    output logic                                          o_dc_we,
    output logic [OPTN_ADDR_WIDTH-1:0]                    o_dc_addr,
    output logic [OPTN_DATA_WIDTH-1:0]                    o_dc_data,
    output logic [OPTN_DATA_WIDTH/8-1:0]                  o_dc_byte_select,
    input  logic                                          i_dc_hit,
    input  logic [OPTN_DATA_WIDTH-1:0]                    i_dc_data
);

    localparam int DATA_SIZE = OPTN_DATA_WIDTH / 8;
    localparam int IDX_W     = (OPTN_NUM_REQ > 1) ? $clog2(OPTN_NUM_REQ) : 1;
    localparam int RC_W      = (OPTN_MAX_RETRY > 1) ? $clog2(OPTN_MAX_RETRY) : 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(OPTN_MAX_RETRY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OPTN_NUM_REQ - 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                     r_state, w_state_nxt;
    logic [IDX_W-1:0]           r_rr_ptr;
    logic [RC_W-1:0]            r_retry_cnt;
    logic                       r_req_we;
    logic [OPTN_ADDR_WIDTH-1:0] r_req_addr;
    logic [OPTN_DATA_WIDTH-1:0] r_req_data;
    logic [DATA_SIZE-1:0]       r_req_bs;
    logic [IDX_W-1:0]           r_req_idx;
    logic [OPTN_NUM_REQ-1:0]    r_resp_valid;
    logic                       r_resp_err;
    logic [OPTN_DATA_WIDTH-1:0] r_resp_data;

    logic                       w_found;
    logic [IDX_W-1:0]           w_grant_idx;
    logic [IDX_W-1:0]           w_cand;
    logic [OPTN_NUM_REQ-1:0]    w_grant_oh;
    logic [OPTN_NUM_REQ-1:0]    w_resp_oh;
    logic                       w_hs;
    logic                       w_done_hit;
    logic                       w_done_err;

    // First valid requester at or above rr_ptr, wrapping modulo N.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int i = 0; i < OPTN_NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + i) % OPTN_NUM_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_grant_oh              = '0;
        w_grant_oh[w_grant_idx] = 1'b1;
        w_resp_oh               = '0;
        w_resp_oh[r_req_idx]    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hs        = 1'b0;
        w_done_hit  = 1'b0;
        w_done_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !rst) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (i_dc_hit) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_retry_cnt == RC_LAST) begin
                    w_done_err  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_retry_cnt  <= '0;
            r_req_we     <= 1'b0;
            r_req_addr   <= '0;
            r_req_data   <= '0;
            r_req_bs     <= '0;
            r_req_idx    <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            if (w_hs) begin
                r_req_we    <= i_req_we[w_grant_idx];
                r_req_addr  <= i_req_addr[w_grant_idx*OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH];
                r_req_data  <= i_req_data[w_grant_idx*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];
                r_req_bs    <= i_req_byte_select[w_grant_idx*DATA_SIZE +: DATA_SIZE];
                r_req_idx   <= w_grant_idx;
                r_rr_ptr    <= (w_grant_idx == IDX_LAST) ? '0 : w_grant_idx + 1'b1;
                r_retry_cnt <= '0;
            end
            if (w_done_hit) begin
                r_resp_valid <= w_resp_oh;
                r_resp_data  <= i_dc_data;
            end else if (w_done_err) begin
                r_resp_valid <= w_resp_oh;
                r_resp_err   <= 1'b1;
            end else if (r_state == S_ACCESS) begin
                r_retry_cnt  <= r_retry_cnt + 1'b1;
            end
        end
    end

    assign o_req_ready      = (r_state == S_IDLE && w_found && !rst) ? w_grant_oh : '0;
    assign o_resp_valid     = r_resp_valid;
    assign o_resp_err       = r_resp_err;
    assign o_resp_data      = r_resp_data;
    assign o_dc_we          = (r_state == S_ACCESS) && r_req_we;
    assign o_dc_addr        = r_req_addr;
    assign o_dc_data        = r_req_data;
    assign o_dc_byte_select = r_req_bs;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: reset, read, write, fairness, retry, exhaustion, abort.
// Inputs change and outputs are sampled just after the falling edge.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_we;
    logic [63:0] req_addr, req_data;
    logic [7:0]  req_bs;
    logic [1:0]  o_req_ready, o_resp_valid;
    logic        o_resp_err;
    logic [31:0] o_resp_data;
    logic        o_dc_we;
    logic [31:0] o_dc_addr, o_dc_data;
    logic [3:0]  o_dc_byte_select;
    logic        dc_hit;
    logic [31:0] dc_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_ram_arbiter #(
        .OPTN_DATA_WIDTH(32), .OPTN_ADDR_WIDTH(32), .OPTN_NUM_REQ(2), .OPTN_MAX_RETRY(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
        .i_req_data(req_data), .i_req_byte_select(req_bs),
        .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid), .o_resp_err(o_resp_err),
        .o_resp_data(o_resp_data), .o_dc_we(o_dc_we), .o_dc_addr(o_dc_addr),
        .o_dc_data(o_dc_data), .o_dc_byte_select(o_dc_byte_select),
        .i_dc_hit(dc_hit), .i_dc_data(dc_rdata)
    );

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11;
        @(negedge clk); @(negedge clk); #1;
        tests++; if (o_req_ready !== 2'b00) begin fails++; $display("FAIL rst_ready got %b exp 00", o_req_ready); end
        tests++; if (o_resp_valid !== 2'b00) begin fails++; $display("FAIL rst_resp_valid got %b exp 00", o_resp_valid); end
        tests++; if (o_resp_err !== 1'b0) begin fails++; $display("FAIL rst_resp_err got %b exp 0", o_resp_err); end
        tests++; if (o_resp_data !== 32'h0) begin fails++; $display("FAIL rst_resp_data got %h exp 0", o_resp_data); end
        tests++; if (o_dc_we !== 1'b0) begin fails++; $display("FAIL rst_dc_we got %b exp 0", o_dc_we); end
        tests++; if (o_dc_addr !== 32'h0) begin fails++; $display("FAIL rst_dc_addr got %h exp 0", o_dc_addr); end
        tests++; if (o_dc_data !== 32'h0) begin fails++; $display("FAIL rst_dc_data got %h exp 0", o_dc_data); end
        tests++; if (o_dc_byte_select !== 4'h0) begin fails++; $display("FAIL rst_dc_bs got %h exp 0", o_dc_byte_select); end
        req_valid = 2'b00; rst = 1'b0;
        @(negedge clk); #1;
        tests++; if (o_req_ready !== 2'b00) begin fails++; $display("FAIL idle_ready got %b exp 00", o_req_ready); end
    endtask

    task automatic test_single_read();
        req_addr[31:0] = 32'h10; req_we = 2'b00; req_valid = 2'b01; #1;
        tests++; if (o_req_ready !== 2'b01) begin fails++; $display("FAIL rd_ready got %b exp 01", o_req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        tests++; if (o_dc_we !== 1'b0) begin fails++; $display("FAIL rd_dc_we got %b exp 0", o_dc_we); end
        tests++; if (o_dc_addr !== 32'h10) begin fails++; $display("FAIL rd_dc_addr got %h exp 10", o_dc_addr); end
        tests++; if (o_req_ready !== 2'b00) begin fails++; $display("FAIL rd_busy_ready got %b exp 00", o_req_ready); end
        dc_hit = 1'b1; dc_rdata = 32'hDEADBEEF;
        @(negedge clk); dc_hit = 1'b0; #1;
        tests++; if (o_resp_valid !== 2'b01) begin fails++; $display("FAIL rd_resp_valid got %b exp 01", o_resp_valid); end
        tests++; if (o_resp_err !== 1'b0) begin fails++; $display("FAIL rd_resp_err got %b exp 0", o_resp_err); end
        tests++; if (o_resp_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_resp_data got %h exp deadbeef", o_resp_data); end
        @(negedge clk); #1;
        tests++; if (o_resp_valid !== 2'b00) begin fails++; $display("FAIL rd_pulse_width got %b exp 00", o_resp_valid); end
    endtask

    task automatic test_write();
        req_addr[63:32] = 32'h04; req_data[63:32] = 32'h11223344; req_bs[7:4] = 4'b0101;
        req_we = 2'b10; req_valid = 2'b10; #1;
        tests++; if (o_req_ready !== 2'b10) begin fails++; $display("FAIL wr_ready got %b exp 10", o_req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        tests++; if (o_dc_we !== 1'b1) begin fails++; $display("FAIL wr_dc_we got %b exp 1", o_dc_we); end
        tests++; if (o_dc_addr !== 32'h04) begin fails++; $display("FAIL wr_dc_addr got %h exp 04", o_dc_addr); end
        tests++; if (o_dc_data !== 32'h11223344) begin fails++; $display("FAIL wr_dc_data got %h exp 11223344", o_dc_data); end
        tests++; if (o_dc_byte_select !== 4'b0101) begin fails++; $display("FAIL wr_dc_bs got %b exp 0101", o_dc_byte_select); end
        dc_hit = 1'b1;
        @(negedge clk); dc_hit = 1'b0; #1;
        tests++; if (o_dc_we !== 1'b0) begin fails++; $display("FAIL wr_we_drop got %b exp 0", o_dc_we); end
        tests++; if (o_resp_valid !== 2'b10) begin fails++; $display("FAIL wr_resp_valid got %b exp 10", o_resp_valid); end
        tests++; if (o_resp_err !== 1'b0) begin fails++; $display("FAIL wr_resp_err got %b exp 0", o_resp_err); end
    endtask

    task automatic test_fairness();
        logic [1:0] oh, prev;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        req_addr = {32'h200, 32'h100}; req_we = 2'b00; req_valid = 2'b11; dc_hit = 1'b1; dc_rdata = 32'h0;
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            tests++; if (o_req_ready !== oh) begin fails++; $display("FAIL fair_grant%0d got %b exp %b", k, o_req_ready, oh); end
            tests++; if (o_resp_valid !== prev) begin fails++; $display("FAIL fair_resp%0d got %b exp %b", k, o_resp_valid, prev); end
            @(negedge clk); #1;
            tests++; if (o_dc_addr !== ((k % 2 == 0) ? 32'h100 : 32'h200)) begin fails++; $display("FAIL fair_addr%0d got %h", k, o_dc_addr); end
            tests++; if (o_req_ready !== 2'b00) begin fails++; $display("FAIL fair_busy%0d got %b exp 00", k, o_req_ready); end
            prev = oh;
            @(negedge clk);
        end
        #1;
        tests++; if (o_resp_valid !== 2'b10) begin fails++; $display("FAIL fair_last_resp got %b exp 10", o_resp_valid); end
        req_valid = 2'b00; dc_hit = 1'b0;
    endtask

    task automatic test_miss_retry();
        req_addr[31:0] = 32'h40; req_data[31:0] = 32'hCAFE0001; req_bs[3:0] = 4'hF;
        req_we = 2'b01; req_valid = 2'b01; dc_hit = 1'b0; dc_rdata = 32'h55AA55AA; #1;
        tests++; if (o_req_ready !== 2'b01) begin fails++; $display("FAIL miss_ready got %b exp 01", o_req_ready); end
        @(negedge clk); req_valid = 2'b00;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++; if (o_dc_we !== 1'b1 || o_dc_addr !== 32'h40 || o_dc_data !== 32'hCAFE0001 || o_dc_byte_select !== 4'hF)
                begin fails++; $display("FAIL miss_stable%0d got we=%b a=%h d=%h bs=%h", c, o_dc_we, o_dc_addr, o_dc_data, o_dc_byte_select); end
            tests++; if (o_resp_valid !== 2'b00) begin fails++; $display("FAIL miss_early%0d got %b exp 00", c, o_resp_valid); end
            if (c == 3) dc_hit = 1'b1;
            @(negedge clk);
        end
        dc_hit = 1'b0; #1;
        tests++; if (o_resp_valid !== 2'b01) begin fails++; $display("FAIL miss_resp got %b exp 01", o_resp_valid); end
        tests++; if (o_resp_err !== 1'b0) begin fails++; $display("FAIL miss_err got %b exp 0", o_resp_err); end
        tests++; if (o_resp_data !== 32'h55AA55AA) begin fails++; $display("FAIL miss_data got %h exp 55aa55aa", o_resp_data); end
    endtask

    task automatic test_retry_exhaust();
        req_addr[63:32] = 32'h80; req_bs[7:4] = 4'h3; req_we = 2'b10; req_valid = 2'b10;
        dc_hit = 1'b0; dc_rdata = 32'h0BADF00D; #1;
        tests++; if (o_req_ready !== 2'b10) begin fails++; $display("FAIL exh_ready got %b exp 10", o_req_ready); end
        @(negedge clk); req_valid = 2'b00;
        for (int c = 0; c < 8; c++) begin
            #1;
            tests++; if (o_dc_we !== 1'b1) begin fails++; $display("FAIL exh_we%0d got %b exp 1", c, o_dc_we); end
            tests++; if (o_resp_valid !== 2'b00) begin fails++; $display("FAIL exh_early%0d got %b exp 00", c, o_resp_valid); end
            @(negedge clk);
        end
        #1;
        tests++; if (o_resp_valid !== 2'b10) begin fails++; $display("FAIL exh_resp got %b exp 10", o_resp_valid); end
        tests++; if (o_resp_err !== 1'b1) begin fails++; $display("FAIL exh_err got %b exp 1", o_resp_err); end
        tests++; if (o_resp_data !== 32'h55AA55AA) begin fails++; $display("FAIL exh_data_held got %h exp 55aa55aa", o_resp_data); end
        tests++; if (o_dc_we !== 1'b0) begin fails++; $display("FAIL exh_we_drop got %b exp 0", o_dc_we); end
        @(negedge clk); #1;
        tests++; if (o_resp_valid !== 2'b00 || o_resp_err !== 1'b0) begin fails++; $display("FAIL exh_pulse got v=%b e=%b exp 00/0", o_resp_valid, o_resp_err); end
    endtask

    task automatic test_reset_mid_access();
        req_addr[31:0] = 32'hC0; req_we = 2'b01; req_valid = 2'b01; dc_hit = 1'b0; #1;
        tests++; if (o_req_ready !== 2'b01) begin fails++; $display("FAIL abort_ready got %b exp 01", o_req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        tests++; if (o_dc_we !== 1'b1) begin fails++; $display("FAIL abort_we got %b exp 1", o_dc_we); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        tests++; if (o_resp_valid !== 2'b00 || o_resp_err !== 1'b0 || o_resp_data !== 32'h0)
            begin fails++; $display("FAIL abort_resp got v=%b e=%b d=%h exp 0", o_resp_valid, o_resp_err, o_resp_data); end
        tests++; if (o_dc_we !== 1'b0 || o_dc_addr !== 32'h0 || o_dc_data !== 32'h0 || o_dc_byte_select !== 4'h0)
            begin fails++; $display("FAIL abort_dc got we=%b a=%h d=%h bs=%h exp 0", o_dc_we, o_dc_addr, o_dc_data, o_dc_byte_select); end
        tests++; if (o_req_ready !== 2'b00) begin fails++; $display("FAIL abort_rst_ready got %b exp 00", o_req_ready); end
        rst = 1'b0; req_valid = 2'b11; req_we = 2'b00; #1;
        tests++; if (o_req_ready !== 2'b01) begin fails++; $display("FAIL abort_prio got %b exp 01", o_req_ready); end
        req_valid = 2'b00;
        @(negedge clk); #1;
        tests++; if (o_resp_valid !== 2'b00 || o_dc_we !== 1'b0) begin fails++; $display("FAIL abort_quiet got v=%b we=%b exp 00/0", o_resp_valid, o_dc_we); end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_data = '0; req_bs = '0;
        dc_hit = 1'b0; dc_rdata = '0;
        test_reset();
        test_single_read();
        test_write();
        test_fairness();
        test_miss_retry();
        test_retry_exhaust();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Round-robin arbiter and access sequencer that shares the single-port data RAM between `OPTN_NUM_REQ` requesters (LSU load/store ports, debug/loader port). It accepts one request at a time over a valid/ready handshake, registers it, and drives the RAM interface. It retries on a RAM miss, bounded by a retry limit, and returns a registered response to the granted requester.

## Interface
- `OPTN_DATA_WIDTH`, 32, data width; byte-select width `DATA_SIZE = OPTN_DATA_WIDTH/8`
- `OPTN_ADDR_WIDTH`, 32, address width
- `OPTN_NUM_REQ`, 2, number of requesters (≥2)
- `OPTN_MAX_RETRY`, 8, maximum ACCESS cycles per request before error (≥1)

- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `i_req_valid`  in  N  request valid, one bit per requester
- `i_req_we`  in  N  1 = write, 0 = read
- `i_req_addr`  in  N×ADDR  flattened; requester k at `[k*ADDR +: ADDR]`
- `i_req_data`  in  N×DATA  write data, flattened
- `i_req_byte_select`  in  N×DATA_SIZE  byte enables, flattened
- `o_req_ready`  out  N  one-hot grant; the handshake completes when valid & ready
- `o_resp_valid`  out  N  one-cycle pulse to the requester whose access completed
- `o_resp_err`  out  1  qualifies `o_resp_valid`; 1 = retry limit exhausted
- `o_resp_data`  out  DATA  read data (shared bus)
- `o_dc_we`, `o_dc_addr`, `o_dc_data`, `o_dc_byte_select`  out  1/ADDR/DATA/DATA_SIZE  RAM request
- `i_dc_hit`  in  1  RAM access completed this cycle
- `i_dc_data`  in  DATA  RAM combinational read data

## Operation
- States: IDLE, ACCESS.
- **IDLE**
  - The grant is the first requester with `i_req_valid` high, searching from `rr_ptr` upward modulo N.
  - `o_req_ready` is high for that requester only, combinationally from `i_req_valid`. It is all-zero when no request is valid.
  - On handshake: capture we/addr/data/byte_select and the grantee index into the request register, and set `rr_ptr` to (grantee+1) mod N. Clear `retry_cnt`. Go to ACCESS.
- **ACCESS**
  - Drive the RAM from the request register: `o_dc_addr`, `o_dc_data` and `o_dc_byte_select` come from the register, and `o_dc_we` equals the captured we.
  - `o_req_ready` is all-zero.
  - If `i_dc_hit`: register `i_dc_data` into `o_resp_data`, pulse `o_resp_valid[grantee]` with `o_resp_err` = 0 next cycle, and go to IDLE.
  - If not `i_dc_hit` and `retry_cnt == OPTN_MAX_RETRY-1`: pulse `o_resp_valid[grantee]` with `o_resp_err` = 1 next cycle, leave `o_resp_data` unchanged, and go to IDLE.
  - Otherwise: increment `retry_cnt` and stay in ACCESS with identical RAM outputs. Repeated writes are idempotent.
- Outside ACCESS: `o_dc_we` = 0, and the other RAM outputs hold the request register contents.
- Writes also produce a response, with `o_resp_err` = 0 on hit. `o_resp_data` is loaded with `i_dc_data`; requesters ignore it.
- Byte-select all-zero is legal: the access is sequenced normally and the RAM modifies nothing.
- Addresses pass through unmodified; alignment and wrap are the RAM's concern.
- `retry_cnt` width is `$clog2(OPTN_MAX_RETRY)` (minimum 1 bit). It never exceeds `OPTN_MAX_RETRY-1`.

## Timing
- Handshake at edge T. ACCESS during cycle T+1. With an immediate hit, the write commits at the end of T+1, and `o_resp_valid` plus data are registered and visible during T+2.
- The FSM is back in IDLE during T+2, so a new grant can occur in the same cycle as the response pulse. Peak throughput is one access per 2 cycles.
- A miss adds one cycle per retry. The worst case is `OPTN_MAX_RETRY` ACCESS cycles, then the error response.
- `o_resp_valid` is high exactly one cycle per accepted request. At most one bit is set.
- Requesters hold valid and payload until ready. Deasserting valid before the handshake withdraws the request without side effects.
- Reset state, applied on the edge where `rst` = 1:
  - FSM = IDLE, `rr_ptr` = 0, `retry_cnt` = 0.
  - `o_resp_valid` = 0, `o_resp_err` = 0, `o_resp_data` = 0.
  - Request register = 0, so `o_dc_we` = 0, `o_dc_addr` = 0, `o_dc_data` = 0, `o_dc_byte_select` = 0.
  - `o_req_ready` = 0 while `rst` is high.
- Reset mid-ACCESS aborts the request: no response is issued, and a write is not retried.

## Test plan
- Single read, req0: addr 0x10, `i_dc_hit` = 1, `i_dc_data` = 0xDEADBEEF → `o_dc_we` = 0 in T+1; `o_resp_valid` = 2'b01, `o_resp_err` = 0 and `o_resp_data` = 0xDEADBEEF in T+2.
- Write, req1: addr 0x04, data 0x11223344, byte_select 4'b0101 → exactly one cycle of `o_dc_we` = 1 with those values; `o_resp_valid` = 2'b10 in T+2.
- Fairness: both requesters continuously valid from reset → grants alternate req0, req1, req0, req1, each 2 cycles apart; `rr_ptr` toggles.
- Miss retry: `i_dc_hit` low for 3 ACCESS cycles, then high → RAM outputs stable for 4 cycles; response 5 cycles after the handshake with `o_resp_err` = 0.
- Retry exhaustion: `i_dc_hit` held low, `OPTN_MAX_RETRY` = 8 → 8 ACCESS cycles, then `o_resp_err` = 1 pulse; FSM returns to IDLE and `o_dc_we` drops.
- Reset mid-ACCESS of a write with hit low → no `o_resp_valid`; all outputs 0 the cycle after reset; next request is served from req0 priority.
